calc_seq: RTL and testbench

Calculation sequencer between `cmd_interp` and the UART transmit path. On each completed entry it latches the two operands and the one-hot command, then runs the operation on a shared iterative datapath: one cycle for add/sub, eight for mul/div. It converts the signed result to decimal ASCII and streams the characters to the transmitter over a valid/ready byte handshake. It ignores new requests until the whole answer has been sent.

---
 rtl/calc_seq.sv | 216 +++++++++++++++++++++
 tb/tb_calc_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq.sv
// calc_seq: latches two operands and a one-hot command, computes on a
// shared iterative datapath and streams the signed decimal answer + CR.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   rdy               rising edge requests an operation (sampled in IDLE)
//   op_a, op_b, cmd   operands and one-hot command (add/sub/mul/div)
//   tx_data/valid/ready  ASCII byte stream to the transmitter
//   result, err       last result / invalid-operation flag
//   busy, done        not-IDLE level / pulse after the final CR transfer
module calc_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [3:0]         cmd,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               busy,
    output logic               done
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CALC  = 3'd1;
    localparam logic [2:0] SIGN  = 3'd2;
    localparam logic [2:0] DIGIT = 3'd3;
    localparam logic [2:0] SEND  = 3'd4;
    localparam logic [2:0] TERM  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       ret;
    logic             rdy_q;
    logic [3:0]       cmd_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    mcand;
    logic [RW-1:0]    acc;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    mag;
    logic [1:0]       pidx;
    logic [3:0]       dcnt;
    logic             seen;

    logic             start;
    logic             bad;
    logic             last;
    logic             div_bit;
    logic [RW-1:0]    mul_next;
    logic [RW-1:0]    div_next;
    logic [RW-1:0]    sub_res;
    logic [RW-1:0]    pw;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_next;

    assign busy = (state != IDLE);

    always_comb begin
        start    = rdy & ~rdy_q & (state == IDLE);
        bad      = !$onehot(cmd_q) || (cmd_q[3] && (b_q == '0));
        last     = (cnt == CW'(WIDTH - 1));
        // mul: b_q shifts right, mcand shifts left, one partial per cycle
        mul_next = acc + (b_q[0] ? mcand : '0);
        // div: a_q shifts out MSB first into the remainder
        rem_sh   = (rem << 1) | (WIDTH + 1)'(a_q[WIDTH-1]);
        div_bit  = (rem_sh >= {1'b0, b_q});
        rem_next = div_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
        div_next = (acc << 1) | RW'(div_bit);
        sub_res  = RW'(a_q) - RW'(b_q);
        case (pidx)
            2'd0:    pw = RW'(1000);
            2'd1:    pw = RW'(100);
            2'd2:    pw = RW'(10);
            default: pw = RW'(1);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ret      <= IDLE;
            // Treat a level already high at reset release as old, so
            // only a fresh rising edge can start an operation.
            rdy_q    <= 1'b1;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            mcand    <= '0;
            acc      <= '0;
            rem      <= '0;
            cnt      <= '0;
            mag      <= '0;
            pidx     <= '0;
            dcnt     <= '0;
            seen     <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            result   <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            rdy_q <= rdy;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_q <= cmd;
                        a_q   <= op_a;
                        b_q   <= op_b;
                        mcand <= RW'(op_a);
                        acc   <= '0;
                        rem   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (bad) begin
                        err      <= 1'b1;
                        tx_data  <= 8'h45;
                        tx_valid <= 1'b1;
                        ret      <= TERM;
                        state    <= SEND;
                    end else begin
                        unique case (1'b1)
                            cmd_q[0]: begin
                                result <= RW'(a_q) + RW'(b_q);
                                state  <= SIGN;
                            end
                            cmd_q[1]: begin
                                result <= sub_res;
                                state  <= SIGN;
                            end
                            cmd_q[2]: begin
                                acc   <= mul_next;
                                mcand <= mcand << 1;
                                b_q   <= b_q >> 1;
                                cnt   <= cnt + 1'b1;
                                if (last) begin
                                    result <= mul_next;
                                    state  <= SIGN;
                                end
                            end
                            cmd_q[3]: begin
                                acc <= div_next;
                                rem <= rem_next;
                                a_q <= a_q << 1;
                                cnt <= cnt + 1'b1;
                                if (last) begin
                                    result <= div_next;
                                    state  <= SIGN;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                SIGN: begin
                    pidx <= '0;
                    dcnt <= '0;
                    seen <= 1'b0;
                    if (result[RW-1]) begin
                        mag      <= -result;
                        tx_data  <= 8'h2D;
                        tx_valid <= 1'b1;
                        ret      <= DIGIT;
                        state    <= SEND;
                    end else begin
                        mag   <= result;
                        state <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (mag >= pw) begin
                        mag  <= mag - pw;
                        dcnt <= dcnt + 1'b1;
                    end else begin
                        pidx <= pidx + 1'b1;
                        dcnt <= '0;
                        if ((dcnt != '0) || seen || (pidx == 2'd3)) begin
                            tx_data  <= 8'h30 + {4'h0, dcnt};
                            tx_valid <= 1'b1;
                            seen     <= 1'b1;
                            ret      <= (pidx == 2'd3) ? TERM : DIGIT;
                            state    <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= ret;
                        if (ret == IDLE) begin
                            done <= 1'b1;
                        end
                    end
                end
                TERM: begin
                    tx_data  <= 8'h0D;
                    tx_valid <= 1'b1;
                    ret      <= IDLE;
                    state    <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed bench for calc_seq with a decimal-string model,
// one per-cycle compare process and literal result/byte expectations.
module tb_calc_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [7:0]  op_a = 8'h00;
    logic [7:0]  op_b = 8'h00;
    logic [3:0]  cmd = 4'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [15:0] result;
    logic        err;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_done = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_res = 16'h0;
    logic [15:0] prev_res = 16'h0;
    logic        exp_err = 1'b0;
    int          exp_lat = 0;
    bit          bp = 1'b0;
    int          wcnt = 0;
    logic [63:0] rx_word = 64'h0;

    logic        pv = 1'b0;
    logic        px = 1'b0;
    logic        pcr = 1'b0;
    logic        pb = 1'b0;
    logic        got = 1'b1;
    logic [7:0]  pd = 8'h00;
    int          lat = 0;
    logic [8:0]  expb;

    always #5 clk = ~clk;

    calc_seq dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .op_a     (op_a),
        .op_b     (op_b),
        .cmd      (cmd),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .result   (result),
        .err      (err),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Expected string, result, err and first-byte latency from the
    // arithmetic rules and the per-power digit cost (count+1 cycles).
    task automatic load_model(input int a, input int b, input logic [3:0] c);
        int    r;
        int    m;
        int    clen;
        int    d;
        int    p;
        bit    e;
        string s;
        e = 1'b0;
        r = 0;
        clen = 1;
        case (c)
            4'b0001: r = a + b;
            4'b0010: r = a - b;
            4'b0100: begin r = a * b; clen = 8; end
            4'b1000: begin
                clen = 8;
                if (b == 0) e = 1'b1;
                else r = a / b;
            end
            default: e = 1'b1;
        endcase
        exp_err = e;
        if (e) begin
            exp_res = prev_res;
            exp_q.push_back(8'h45);
            exp_lat = 1;
        end else begin
            exp_res = r[15:0];
            prev_res = exp_res;
            m = (r < 0) ? -r : r;
            if (r < 0) exp_q.push_back(8'h2D);
            s = $sformatf("%0d", m);
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            exp_lat = clen + 1;
            if (r >= 0) begin
                p = 1000;
                for (int k = 0; k < 4; k++) begin
                    d = m / p;
                    exp_lat += d + 1;
                    if (d != 0 || p == 1) break;
                    p = p / 10;
                end
            end
        end
        exp_q.push_back(8'h0D);
    endtask

    task automatic run_op(input int a, input int b, input logic [3:0] c,
                          input bit with_bp, input bit poke);
        bit seen_done;
        int snap;
        rdy = 1'b0;
        @(posedge clk);
        #1;
        op_a = a[7:0];
        op_b = b[7:0];
        cmd = c;
        bp = with_bp;
        load_model(a, b, c);
        snap = n_done;
        rdy = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 400 && !seen_done; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (poke && i == 10) begin #1; rdy = 1'b0; op_a = 8'd50; end
            if (poke && i == 11) begin #1; rdy = 1'b1; end
        end
        check("done_seen", seen_done, 1);
        @(negedge clk);
        @(negedge clk);
        check("one_done_pulse", n_done - snap, 1);
        bp = 1'b0;
    endtask

    // Transmitter: ready tied high, or held low 5 cycles per byte.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!bp) tx_ready = 1'b1;
            else if (!tx_valid) begin tx_ready = 1'b0; wcnt = 0; end
            else if (wcnt < 5) begin tx_ready = 1'b0; wcnt++; end
            else tx_ready = 1'b1;
        end
    end

    // Compare process: checks the byte stream and status every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0; px = 1'b0; pcr = 1'b0; pb = 1'b0; got = 1'b1;
            end else begin
                if (busy && !pb) begin
                    lat = 0; got = 1'b0; rx_word = 64'h0;
                end
                if (busy && !got) begin
                    if (tx_valid) begin
                        check("first_byte_latency", lat, exp_lat);
                        got = 1'b1;
                    end else begin
                        lat++;
                    end
                end
                if (tx_valid) check("valid_only_busy", busy, 1);
                if (pv && !px) begin
                    check("valid_hold", tx_valid, 1);
                    check("data_hold", tx_data, pd);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() != 0) expb = {1'b0, exp_q.pop_front()};
                    else expb = 9'h1FF;
                    check("tx_byte", {1'b0, tx_data}, expb);
                    rx_word = (rx_word << 8) | 64'(tx_data);
                end
                if (done || pcr) check("done_after_cr", done, pcr);
                if (done) begin
                    n_done++;
                    check("busy_at_done", busy, 0);
                    check("queue_drained", exp_q.size(), 0);
                    check("result", result, exp_res);
                    check("err", err, exp_err);
                end
                pv = tx_valid;
                px = tx_valid && tx_ready;
                pd = tx_data;
                pcr = px && (tx_data == 8'h0D);
                pb = busy;
            end
        end
    end

    initial begin
        int  nval;
        bit  hit;
        logic pvl;
        #2;
        rst = 1'b0;
        #10;
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_result", result, 16'h0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_op(12, 34, 4'b0001, 0, 0);
        check("lit_add_res", result, 16'h002E);
        check("lit_add_err", err, 0);
        check("lit_add_bytes", rx_word, 64'h34360D);

        run_op(5, 37, 4'b0010, 0, 0);
        check("lit_sub_res", result, 16'hFFE0);
        check("lit_sub_bytes", rx_word, 64'h2D33320D);

        run_op(99, 99, 4'b0100, 0, 0);
        check("lit_mul_res", result, 16'h2649);
        check("lit_mul_bytes", rx_word, 64'h393830310D);

        run_op(99, 7, 4'b1000, 0, 0);
        check("lit_div_res", result, 16'h000E);
        check("lit_div_bytes", rx_word, 64'h31340D);

        run_op(7, 0, 4'b1000, 0, 0);
        check("lit_div0_err", err, 1);
        check("lit_div0_res", result, 16'h000E);
        check("lit_div0_bytes", rx_word, 64'h450D);

        run_op(0, 0, 4'b0001, 0, 0);
        check("lit_zero_bytes", rx_word, 64'h300D);

        run_op(3, 3, 4'b0110, 0, 0);
        check("lit_badcmd_err", err, 1);
        check("lit_badcmd_res", result, 16'h0000);

        run_op(12, 34, 4'b0001, 1, 1);
        check("lit_bp_bytes", rx_word, 64'h34360D);
        repeat (5) @(negedge clk);
        check("no_restart_busy", busy, 0);

        rdy = 1'b0;
        @(posedge clk);
        #1;
        op_a = 8'd99;
        op_b = 8'd99;
        cmd = 4'b0100;
        load_model(99, 99, 4'b0100);
        rdy = 1'b1;
        nval = 0;
        hit = 1'b0;
        pvl = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge clk);
            if (tx_valid && !pvl) nval++;
            pvl = tx_valid;
            if (nval == 2) hit = 1'b1;
        end
        check("second_send_reached", hit, 1);
        #1;
        rst = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_result", result, 16'h0);
        check("arst_err", err, 0);
        exp_q.delete();
        prev_res = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("held_rdy_no_start", busy, 0);

        run_op(3, 4, 4'b0001, 0, 0);
        check("lit_post_rst_res", result, 16'h0007);
        check("lit_post_rst_bytes", rx_word, 64'h370D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
